identificador_compuertas: RTL and testbench

- Sequential tester and decoder for two-input gate outputs; the receiving end of the team's gate set.
- Drives the four input vectors {a,b} = 00, 01, 10, 11 into a single-output gate under test and samples its response.
- Assembles a 4-bit truth table and decodes it into one of the seven known gate functions: NOT(a), AND, NAND, OR, NOR, XOR, XNOR.
- Sits on the lab board between the gate block's outputs (selected externally) and the status LEDs/display.

---
 rtl/identificador_compuertas.sv | 120 ++++++++++++
 tb/tb_identificador_compuertas.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/identificador_compuertas.sv
// Two-input gate identifier: walks {a,b} through 00..11, samples the gate
// response after SETTLE cycles per vector and decodes the truth table.
module identificador_compuertas #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_code,
  output logic       valid
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DECODE,
    DONE
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(SETTLE - 1);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [3:0] samples;

  // Table bit i holds y for vector i = {a,b}.
  function automatic logic [2:0] lookup(input logic [3:0] t);
    logic [2:0] code;
    case (t)
      4'b0011: code = 3'd1;
      4'b1000: code = 3'd2;
      4'b0111: code = 3'd3;
      4'b1110: code = 3'd4;
      4'b0001: code = 3'd5;
      4'b0110: code = 3'd6;
      4'b1001: code = 3'd7;
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 8'd0;
      samples   <= 4'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth     <= 4'd0;
      gate_code <= 3'd0;
      valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= APPLY;
            idx   <= 2'd0;
            cnt   <= 8'd0;
            a_out <= 1'b0;
            b_out <= 1'b0;
            busy  <= 1'b1;
          end
        end
        APPLY: begin
          if (cnt == LAST_WAIT) begin
            state <= SAMPLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SAMPLE: begin
          samples[idx] <= y_in;
          if (idx == 2'd3) begin
            state <= DECODE;
          end else begin
            idx            <= idx + 2'd1;
            cnt            <= 8'd0;
            {a_out, b_out} <= idx + 2'd1;
            state          <= APPLY;
          end
        end
        DECODE: begin
          truth     <= samples;
          gate_code <= lookup(samples);
          valid     <= (lookup(samples) != 3'd0);
          a_out     <= 1'b0;
          b_out     <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          a_out <= 1'b0;
          b_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_identificador_compuertas.sv
// Scoreboard bench: two instances (SETTLE=2 and SETTLE=1) driving modelled
// gates; expected results are queued at start and checked on done.
module tb_identificador_compuertas;

  typedef struct {
    logic [3:0] truth;
    logic [2:0] code;
    int         accept;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_v, a_v, b_v, y_v, busy_v, done_v, valid_v;
  logic [3:0] truth_v [2];
  logic [2:0] code_v  [2];
  logic [3:0] tt0, tt1;
  logic [3:0] last_t [2];
  logic [2:0] last_c [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;

  assign y_v[0] = tt0[{a_v[0], b_v[0]}];
  assign y_v[1] = tt1[{a_v[1], b_v[1]}];

  identificador_compuertas #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_out(a_v[0]), .b_out(b_v[0]),
    .y_in(y_v[0]), .busy(busy_v[0]), .done(done_v[0]), .truth(truth_v[0]),
    .gate_code(code_v[0]), .valid(valid_v[0]));

  identificador_compuertas #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_out(a_v[1]), .b_out(b_v[1]),
    .y_in(y_v[1]), .busy(busy_v[1]), .done(done_v[1]), .truth(truth_v[1]),
    .gate_code(code_v[1]), .valid(valid_v[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Truth table of gate g (1..7) evaluated over the four vectors.
  function automatic logic [3:0] gate_tt(input int g);
    logic [3:0] t;
    logic a, b, y;
    t = 4'd0;
    for (int i = 0; i < 4; i++) begin
      a = (i >= 2);
      b = (i % 2 == 1);
      case (g)
        1: y = !a;
        2: y = a && b;
        3: y = !(a && b);
        4: y = a || b;
        5: y = !(a || b);
        6: y = a != b;
        7: y = a == b;
        default: y = 1'b0;
      endcase
      t[i] = y;
    end
    return t;
  endfunction

  function automatic logic [2:0] model_code(input logic [3:0] t);
    for (int g = 1; g <= 7; g++)
      if (gate_tt(g) == t) return 3'(g);
    return 3'd0;
  endfunction

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int settle_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  task automatic chk_zero(input int u);
    chk($sformatf("rst_a_%0d", u), a_v[u], 0);
    chk($sformatf("rst_b_%0d", u), b_v[u], 0);
    chk($sformatf("rst_busy_%0d", u), busy_v[u], 0);
    chk($sformatf("rst_done_%0d", u), done_v[u], 0);
    chk($sformatf("rst_truth_%0d", u), truth_v[u], 0);
    chk($sformatf("rst_code_%0d", u), code_v[u], 0);
    chk($sformatf("rst_valid_%0d", u), valid_v[u], 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        if (done_v[u]) begin
          if (qsize(u) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done unit %0d got done=1 expected none", u);
          end else begin
            if (u == 0) mon_e = q0.pop_front();
            else        mon_e = q1.pop_front();
            chk($sformatf("truth_%0d", u), truth_v[u], mon_e.truth);
            chk($sformatf("code_%0d", u), code_v[u], mon_e.code);
            chk($sformatf("valid_%0d", u), valid_v[u], (mon_e.code != 0) ? 1 : 0);
            chk($sformatf("latency_%0d", u), cyc - mon_e.accept, 4 * (settle_of(u) + 1) + 1);
            chk($sformatf("busy_at_done_%0d", u), busy_v[u], 0);
          end
        end
      end
    end
  end

  // One run on unit u; extra_k re-asserts start while busy, abort_k resets mid-run.
  task automatic run(input int u, input logic [3:0] tt_in, input int extra_k, input int abort_k);
    exp_t e;
    int s, total, n;
    s = settle_of(u);
    total = 4 * (s + 1);
    @(negedge clk);
    if (u == 0) tt0 = tt_in; else tt1 = tt_in;
    e.truth  = tt_in;
    e.code   = model_code(tt_in);
    e.accept = cyc + 1;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    start_v[u] = 1'b1;
    @(negedge clk);
    start_v[u] = 1'b0;
    for (int k = 0; k <= total; k++) begin
      if (k == 0) begin
        chk($sformatf("held_truth_%0d", u), truth_v[u], last_t[u]);
        chk($sformatf("held_code_%0d", u), code_v[u], last_c[u]);
      end
      if (k == abort_k) begin
        #2 rst = 1'b1;
        #1 chk_zero(0);
        chk_zero(1);
        q0.delete();
        q1.delete();
        for (int v = 0; v < 2; v++) begin
          last_t[v] = 4'd0;
          last_c[v] = 3'd0;
        end
        start_v = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (k < total) chk($sformatf("vector_%0d", u), {a_v[u], b_v[u]}, k / (s + 1));
      chk($sformatf("busy_%0d", u), busy_v[u], 1);
      start_v[u] = (k == extra_k);
      @(negedge clk);
    end
    start_v[u] = 1'b0;
    last_t[u] = e.truth;
    last_c[u] = e.code;
    n = 0;
    while (qsize(u) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (qsize(u) != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout unit %0d got no done expected one", u);
      if (u == 0) q0.delete(); else q1.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    start_v = 2'b00;
    tt0 = 4'd0;
    tt1 = 4'd0;
    for (int v = 0; v < 2; v++) begin
      last_t[v] = 4'd0;
      last_c[v] = 3'd0;
    end
    #3 chk_zero(0);
    chk_zero(1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(0, gate_tt(2), -1, -1);
    for (int g = 1; g <= 7; g++) run(0, gate_tt(g), -1, -1);
    run(0, 4'b1111, -1, -1);
    run(0, 4'b0000, -1, -1);
    run(0, gate_tt(6), -1, -1);
    run(0, gate_tt(2), 1, -1);
    repeat (5) @(negedge clk);
    run(0, gate_tt(2), -1, 6);
    repeat (3) @(negedge clk);
    run(1, gate_tt(5), -1, -1);
    run(0, gate_tt(4), -1, -1);
    repeat (8) run(0, 4'($urandom), -1, -1);
    repeat (4) run(1, 4'($urandom), -1, -1);
    repeat (20) @(negedge clk);
    chk("queue_empty_0", q0.size(), 0);
    chk("queue_empty_1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
